// File: rtl/cla_add_arbiter_pkg.sv
// Shared constants, state encoding and the round-robin pick helper for the
// shared 12-bit carry-lookahead adder arbiter.
package cla_add_arbiter_pkg;

   localparam int ADD_W   = 12;
   localparam int NUM_REQ = 4;
   localparam int REQ_IDW = 2;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   // Index arithmetic wraps naturally because NUM_REQ is a power of two.
   function automatic logic [NUM_REQ-1:0] rr_grant(
      input logic [NUM_REQ-1:0] valid,
      input logic [REQ_IDW-1:0] last
   );
      logic [NUM_REQ-1:0] gnt;
      logic [REQ_IDW-1:0] idx;
      logic               found;
      gnt   = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx      = last + REQ_IDW'(k);
         gnt[idx] = valid[idx] & ~found;
         found    = found | valid[idx];
      end
      return gnt;
   endfunction

endpackage

// File: rtl/cla_adder_12bit.sv
// 12-bit two-level carry-lookahead adder (three 4-bit groups), carry-in 0,
// carry out of the top bit dropped.
module cla_adder_12bit
   import cla_add_arbiter_pkg::*;
(
   input  logic [ADD_W-1:0] ain,
   input  logic [ADD_W-1:0] bin,
   output logic [ADD_W-1:0] sum
);

   logic [ADD_W-2:0] g_s;
   logic [ADD_W-1:0] p_s;
   logic [ADD_W-1:0] c_s;
   logic [1:0]       gg_s;
   logic [1:0]       gp_s;
   logic [2:0]       gc_s;

   // Bit and group generate/propagate, group carries, then in-group carries.
   always_comb begin
      g_s = ain[ADD_W-2:0] & bin[ADD_W-2:0];
      p_s = ain ^ bin;
      for (int grp = 0; grp < 2; grp++) begin
         gg_s[grp] = g_s[4*grp+3]
                   | (p_s[4*grp+3] & g_s[4*grp+2])
                   | (p_s[4*grp+3] & p_s[4*grp+2] & g_s[4*grp+1])
                   | (p_s[4*grp+3] & p_s[4*grp+2] & p_s[4*grp+1] & g_s[4*grp]);
         gp_s[grp] = &p_s[4*grp +: 4];
      end
      gc_s[0] = 1'b0;
      gc_s[1] = gg_s[0];
      gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]);
      for (int grp = 0; grp < 3; grp++) begin
         c_s[4*grp]   = gc_s[grp];
         c_s[4*grp+1] = g_s[4*grp] | (p_s[4*grp] & gc_s[grp]);
         c_s[4*grp+2] = g_s[4*grp+1]
                      | (p_s[4*grp+1] & g_s[4*grp])
                      | (p_s[4*grp+1] & p_s[4*grp] & gc_s[grp]);
         c_s[4*grp+3] = g_s[4*grp+2]
                      | (p_s[4*grp+2] & g_s[4*grp+1])
                      | (p_s[4*grp+2] & p_s[4*grp+1] & g_s[4*grp])
                      | (p_s[4*grp+2] & p_s[4*grp+1] & p_s[4*grp] & gc_s[grp]);
      end
      sum = p_s ^ c_s;
   end

endmodule

// File: rtl/cla_add_arbiter.sv
// Round-robin arbiter sharing one 12-bit CLA adder among four requesters,
// with a single-entry result register drained by a ready/valid consumer.
module cla_add_arbiter
   import cla_add_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*ADD_W-1:0]   req_a,
   input  logic [NUM_REQ*ADD_W-1:0]   req_b,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ADD_W-1:0]           rsp_sum,
   output logic [REQ_IDW-1:0]         rsp_id,
   output logic                       busy
);

   state_e             state_r;
   state_e             state_nxt_s;
   logic [REQ_IDW-1:0] last_grant_r;
   logic [REQ_IDW-1:0] last_grant_nxt_s;
   logic [REQ_IDW-1:0] rsp_id_r;
   logic [REQ_IDW-1:0] rsp_id_nxt_s;
   logic [ADD_W-1:0]   rsp_sum_r;
   logic [ADD_W-1:0]   rsp_sum_nxt_s;
   logic [REQ_IDW-1:0] grant_idx_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [NUM_REQ-1:0] ready_s;
   logic [ADD_W-1:0]   opa_s;
   logic [ADD_W-1:0]   opb_s;
   logic [ADD_W-1:0]   sum_s;
   logic               slot_free_s;
   logic               accept_s;

   // Grant is offered only while out of reset and the result slot can take a new sum.
   always_comb begin
      slot_free_s = (state_r == EMPTY) || rsp_ready;
      grant_s     = rr_grant(req_valid, last_grant_r);
      if (rst_n && slot_free_s) begin
         ready_s = grant_s;
      end else begin
         ready_s = '0;
      end
      accept_s = |ready_s;
   end

   // One-hot grant to index.
   always_comb begin
      case (grant_s)
         4'b0001: grant_idx_s = 2'd0;
         4'b0010: grant_idx_s = 2'd1;
         4'b0100: grant_idx_s = 2'd2;
         4'b1000: grant_idx_s = 2'd3;
         default: grant_idx_s = 2'd0;
      endcase
   end

   // Granted requester's operands feed the shared adder.
   always_comb begin
      opa_s = req_a[int'(grant_idx_s)*ADD_W +: ADD_W];
      opb_s = req_b[int'(grant_idx_s)*ADD_W +: ADD_W];
   end

   cla_adder_12bit u_adder (
      .ain (opa_s),
      .bin (opb_s),
      .sum (sum_s)
   );

   // Next state and result register loads.
   always_comb begin
      state_nxt_s      = state_r;
      last_grant_nxt_s = last_grant_r;
      rsp_sum_nxt_s    = rsp_sum_r;
      rsp_id_nxt_s     = rsp_id_r;
      case (state_r)
         EMPTY: begin
            if (accept_s) begin
               state_nxt_s = FULL;
            end else begin
               state_nxt_s = EMPTY;
            end
         end
         FULL: begin
            if (accept_s) begin
               state_nxt_s = FULL;
            end else if (rsp_ready) begin
               state_nxt_s = EMPTY;
            end else begin
               state_nxt_s = FULL;
            end
         end
         default: state_nxt_s = EMPTY;
      endcase
      if (accept_s) begin
         rsp_sum_nxt_s    = sum_s;
         rsp_id_nxt_s     = grant_idx_s;
         last_grant_nxt_s = grant_idx_s;
      end else begin
         rsp_sum_nxt_s    = rsp_sum_r;
         rsp_id_nxt_s     = rsp_id_r;
         last_grant_nxt_s = last_grant_r;
      end
   end

   // State and result registers; last_grant resets to 3 so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= EMPTY;
         last_grant_r <= 2'd3;
         rsp_sum_r    <= 12'h000;
         rsp_id_r     <= 2'd0;
      end else begin
         state_r      <= state_nxt_s;
         last_grant_r <= last_grant_nxt_s;
         rsp_sum_r    <= rsp_sum_nxt_s;
         rsp_id_r     <= rsp_id_nxt_s;
      end
   end

   assign req_ready = ready_s;
   assign rsp_valid = (state_r == FULL);
   assign rsp_sum   = rsp_sum_r;
   assign rsp_id    = rsp_id_r;
   assign busy      = (state_r == FULL) || (|req_valid);

endmodule
